// File: rtl/i2c_txn_scheduler.sv
// rtl/i2c_txn_scheduler.sv - round-robin sequencer sharing the I2C wrapper master port
module i2c_txn_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_CYCLES = 22,
  parameter int WR_CYCLES   = 57,
  parameter int RD_CYCLES   = 66,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             rdata,
  output logic                   busy,
  output logic                   start,
  output logic [7:0]             Data,
  input  logic [7:0]             received_data
);

  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_CYCLES = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam int GAP_LAST   = (GAP_CYCLES > 2) ? GAP_CYCLES - 2 : 0;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_XFER,
    S_DONE,
    S_GAP
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [6:0]         cur_addr;
  logic               cur_rw;
  logic [7:0]         cur_wdata;
  logic [CNT_W-1:0]   cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;
  int                 arb_k;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   last_cnt;
  logic [7:0]         xfer_data;
  logic [IDX_W-1:0]   ptr_nxt;

  // Scan downwards so the smallest offset from the pointer wins.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    arb_k     = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      arb_k = (int'(ptr) + j) % NUM_REQ;
      if (req[arb_k]) begin
        arb_valid = 1'b1;
        arb_idx   = IDX_W'(arb_k);
      end
    end
  end

  always_comb begin
    cnt_nxt   = cnt + CNT_W'(1);
    last_cnt  = cur_rw ? CNT_W'(RD_CYCLES - 1) : CNT_W'(WR_CYCLES - 1);
    xfer_data = (!cur_rw && (cnt_nxt >= CNT_W'(ADDR_CYCLES))) ? cur_wdata : {cur_addr, cur_rw};
    ptr_nxt   = (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cur_idx   <= '0;
      cur_addr  <= '0;
      cur_rw    <= 1'b0;
      cur_wdata <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      start     <= 1'b0;
      Data      <= '0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (arb_valid) begin
            state     <= S_START;
            gnt       <= ONE_HOT0 << arb_idx;
            cur_idx   <= arb_idx;
            cur_addr  <= req_addr[7*arb_idx +: 7];
            cur_rw    <= req_rw[arb_idx];
            cur_wdata <= req_wdata[8*arb_idx +: 8];
            busy      <= 1'b1;
            start     <= 1'b1;
            Data      <= {req_addr[7*arb_idx +: 7], req_rw[arb_idx]};
            cnt       <= '0;
          end
        end
        S_START: begin
          state <= S_XFER;
          start <= 1'b0;
          cnt   <= cnt_nxt;
          Data  <= xfer_data;
        end
        S_XFER: begin
          if (cnt == last_cnt) begin
            state <= S_DONE;
            done  <= gnt;
          end else begin
            cnt  <= cnt_nxt;
            Data <= xfer_data;
          end
        end
        S_DONE: begin
          if (cur_rw) rdata <= received_data;
          ptr     <= ptr_nxt;
          gnt     <= '0;
          Data    <= '0;
          gap_cnt <= '0;
          // The IDLE arbitration cycle is itself the last idle cycle of the gap.
          if (GAP_CYCLES < 2) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// tb/tb_i2c_txn_scheduler.sv - directed self-checking bench for i2c_txn_scheduler
module tb_i2c_txn_scheduler;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [20:0] req_addr;
  logic [2:0]  req_rw;
  logic [23:0] req_wdata;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [7:0]  rdata;
  logic        busy;
  logic        start;
  logic [7:0]  Data;
  logic [7:0]  received_data;

  int errors = 0;
  int checks = 0;

  i2c_txn_scheduler #(
    .NUM_REQ(3), .ADDR_CYCLES(22), .WR_CYCLES(57), .RD_CYCLES(66), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .start(start), .Data(Data), .received_data(received_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    req_addr[7*i +: 7]  = a;
    req_rw[i]           = rw;
    req_wdata[8*i +: 8] = wd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0; req_addr = '0; req_rw = '0; req_wdata = '0; received_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", start); end
    checks++; if (Data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", Data); end
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", gnt); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done got %b want 000", done); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] exp_data;
    set_req(0, 7'h19, 1'b0, 8'h2F);
    req = 3'b001;
    @(negedge clk);
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL wr_latency start got %b want 1", start); end
    req = 3'b000;
    for (int k = 0; k <= 57; k++) begin
      if (k > 0) @(negedge clk);
      exp_data = (k < 22) ? 8'h32 : 8'h2F;
      checks++; if (start !== (k == 0)) begin errors++; $display("FAIL wr_start cyc %0d got %b", k, start); end
      checks++; if (Data !== exp_data) begin errors++; $display("FAIL wr_data cyc %0d got %h want %h", k, Data, exp_data); end
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL wr_gnt cyc %0d got %b want 001", k, gnt); end
      checks++; if (done !== ((k == 57) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL wr_done cyc %0d got %b", k, done); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy cyc %0d got %b want 1", k, busy); end
    end
    @(negedge clk);
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL wr_gap_gnt got %b want 000", gnt); end
    checks++; if (Data !== 8'h00) begin errors++; $display("FAIL wr_gap_data got %h want 00", Data); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL wr_gap_done got %b want 000", done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle_busy got %b want 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_read();
    set_req(1, 7'h19, 1'b1, 8'h00);
    received_data = 8'hAE;
    req = 3'b010;
    @(negedge clk);
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL rd_latency start got %b want 1", start); end
    req = 3'b000;
    for (int k = 0; k <= 67; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= 66) begin
        checks++; if (Data !== 8'h33) begin errors++; $display("FAIL rd_data cyc %0d got %h want 33", k, Data); end
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rd_gnt cyc %0d got %b want 010", k, gnt); end
        checks++; if (done !== ((k == 66) ? 3'b010 : 3'b000)) begin errors++; $display("FAIL rd_done cyc %0d got %b", k, done); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rd_rdata_early cyc %0d got %h want 00", k, rdata); end
      end else begin
        checks++; if (rdata !== 8'hAE) begin errors++; $display("FAIL rd_rdata got %h want AE", rdata); end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_gnt [4];
    logic [2:0] prev;
    int zeros;
    int seen;
    exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100; exp_gnt[3] = 3'b001;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    set_req(0, 7'h10, 1'b0, 8'hA0);
    set_req(1, 7'h11, 1'b0, 8'hA1);
    set_req(2, 7'h12, 1'b0, 8'hA2);
    rst = 1'b1;
    req = 3'b111;
    prev = 3'b000; zeros = 0; seen = 0;
    for (int cyc = 0; cyc < 400 && seen < 4; cyc++) begin
      @(negedge clk);
      if (gnt === 3'b000) begin
        zeros++;
      end else if (gnt !== prev) begin
        checks++; if (gnt !== exp_gnt[seen]) begin errors++; $display("FAIL b2b_order #%0d got %b want %b", seen, gnt, exp_gnt[seen]); end
        if (seen > 0) begin
          checks++; if (zeros != 2) begin errors++; $display("FAIL b2b_gap #%0d got %0d want 2", seen, zeros); end
        end
        zeros = 0;
        seen++;
      end
      prev = gnt;
    end
    checks++; if (seen != 4) begin errors++; $display("FAIL b2b_timeout grants got %0d want 4", seen); end
    req = 3'b000;
    repeat (65) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_req(2, 7'h19, 1'b0, 8'h11);
    req = 3'b100;
    @(negedge clk);
    checks++; if (start !== 1'b1 || gnt !== 3'b100) begin errors++; $display("FAIL rm_first_grant got start=%b gnt=%b want 1/100", start, gnt); end
    repeat (30) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rm_start got %b want 0", start); end
    checks++; if (Data !== 8'h00) begin errors++; $display("FAIL rm_data got %h want 00", Data); end
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rm_gnt got %b want 000", gnt); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL rm_done got %b want 000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
    repeat (2) begin
      @(negedge clk);
      checks++; if (done !== 3'b000) begin errors++; $display("FAIL rm_no_done got %b want 000", done); end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (start !== 1'b1 || gnt !== 3'b100) begin errors++; $display("FAIL rm_regrant got start=%b gnt=%b want 1/100", start, gnt); end
    req = 3'b000;
    for (int k = 1; k <= 57; k++) begin
      @(negedge clk);
      checks++; if (done !== ((k == 57) ? 3'b100 : 3'b000)) begin errors++; $display("FAIL rm_done2 cyc %0d got %b", k, done); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frozen_fields();
    logic [7:0] exp_data;
    set_req(0, 7'h19, 1'b0, 8'h2F);
    req = 3'b001;
    @(negedge clk);
    for (int k = 0; k <= 57; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 10) begin
        req = 3'b000;
        set_req(0, 7'h7F, 1'b1, 8'h55);
      end
      exp_data = (k < 22) ? 8'h32 : 8'h2F;
      checks++; if (Data !== exp_data) begin errors++; $display("FAIL fz_data cyc %0d got %h want %h", k, Data, exp_data); end
      checks++; if (done !== ((k == 57) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL fz_done cyc %0d got %b", k, done); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read_ff();
    set_req(0, 7'h19, 1'b1, 8'hFF);
    received_data = 8'h5A;
    req = 3'b001;
    @(negedge clk);
    checks++; if (start !== 1'b1 || gnt !== 3'b001) begin errors++; $display("FAIL rf_grant got start=%b gnt=%b want 1/001", start, gnt); end
    req = 3'b000;
    for (int k = 0; k <= 67; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= 66) begin
        checks++; if (Data !== 8'h33) begin errors++; $display("FAIL rf_data cyc %0d got %h want 33", k, Data); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rf_rdata_early cyc %0d got %h want 00", k, rdata); end
      end else begin
        checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rf_rdata got %h want 5A", rdata); end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_frozen_fields();
    test_read_ff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
